// File: rtl/code_capture_fifo.sv
// Rising-edge capture of the encoder's 3-bit code into a show-ahead FIFO with a valid/ready drain and sticky overflow.
// Optional macro CODE_PARITY_EN widens each entry with even parity and adds the out_par port.
module code_capture_fifo #(
  parameter int unsigned AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          code_vld,
  input  logic [2:0]    code_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2:0]    out_code,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          overflow,
`ifdef CODE_PARITY_EN
  output logic          out_par,
`endif
  input  logic          clr_ovf
);

  localparam int unsigned DEPTH   = 2 ** AW;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
`ifdef CODE_PARITY_EN
  localparam int unsigned EW = 4;
`else
  localparam int unsigned EW = 3;
`endif

  logic          vld_q, vld_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [EW-1:0] mem_q [DEPTH];

  logic          push_req, push_ok, pop, drop;
  logic [EW-1:0] wdata, head;

  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH_C);
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign out_valid = ~empty;
  assign head      = mem_q[rd_ptr_q];
  assign out_code  = empty ? 3'b000 : head[2:0];
`ifdef CODE_PARITY_EN
  assign out_par   = empty ? 1'b0 : head[3];
  assign wdata     = {^code_in, code_in};
`else
  assign wdata     = code_in;
`endif

  always_comb begin
    push_req = code_vld & ~vld_q;
    pop      = out_valid & out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_ok  = push_req & (~full | pop);
    drop     = push_req & full & ~pop;

    vld_d    = code_vld;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push_ok, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase

    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q    <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: tb/tb_code_capture_fifo.sv
// Directed bench for code_capture_fifo (AW=3): capture, hold, fill/overflow, wrap, clear and async reset.
module tb_code_capture_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       code_vld;
  logic [2:0] code_in;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_code;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       clr_ovf;
`ifdef CODE_PARITY_EN
  logic       out_par;
`endif

  int errors = 0;
  int checks = 0;

  code_capture_fifo #(.AW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .code_vld  (code_vld),
    .code_in   (code_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
`ifdef CODE_PARITY_EN
    .out_par   (out_par),
`endif
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int c);
    code_in  = 3'(c);
    code_vld = 1'b1;
    step();
    code_vld = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; code_vld = 1'b0; code_in = '0; out_ready = 1'b0; clr_ovf = 1'b0;
    repeat (2) step();
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_code", 32'(out_code), 0);
    check("rst_ovf", 32'(overflow), 0);
    rst = 1'b0;
    step();

    // single pulse, no bypass
    code_in = 3'b101; code_vld = 1'b1;
    #1;
    check("pulse_nobypass", 32'(out_valid), 0);
    step();
    code_vld = 1'b0;
    check("pulse_valid", 32'(out_valid), 1);
    check("pulse_code", 32'(out_code), 5);
    check("pulse_count", 32'(count), 1);
    step();
    check("pulse_count_hold", 32'(count), 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("pulse_pop_count", 32'(count), 0);
    check("pulse_pop_code", 32'(out_code), 0);

    // held high: one capture only
    code_vld = 1'b1; code_in = 3'd1;
    step(); code_in = 3'd2;
    step(); code_in = 3'd3;
    step(); step(); step();
    code_vld = 1'b0;
    step();
    check("hold_count", 32'(count), 1);
    check("hold_code", 32'(out_code), 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("hold_drain", 32'(count), 0);

    // simultaneous push & pop with one entry
    push(2);
    code_in = 3'd4; code_vld = 1'b1; out_ready = 1'b1;
    step();
    code_vld = 1'b0; out_ready = 1'b0;
    check("pp_count", 32'(count), 1);
    check("pp_code", 32'(out_code), 4);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("pp_drain", 32'(count), 0);

    // fill 0..7, then one dropped
    for (int i = 0; i < 8; i++) push(i);
    check("fill_count", 32'(count), 8);
    check("fill_full", 32'(full), 1);
    check("fill_ovf", 32'(overflow), 0);
    push(6);
    check("drop_count", 32'(count), 8);
    check("drop_ovf", 32'(overflow), 1);
    check("drop_head", 32'(out_code), 0);

    // set beats clear
    code_in = 3'd3; code_vld = 1'b1; clr_ovf = 1'b1;
    step();
    code_vld = 1'b0;
    check("clr_vs_drop", 32'(overflow), 1);
    step();
    clr_ovf = 1'b0;
    check("clr_alone", 32'(overflow), 0);
    check("clr_count", 32'(count), 8);

    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_%0d", i), 32'(out_code), 32'(i));
      step();
    end
    out_ready = 1'b0;
    check("drain_empty", 32'(empty), 1);
    check("drain_code0", 32'(out_code), 0);

    // full with concurrent pop accepts the push at the wrapped tail
    for (int i = 0; i < 8; i++) push(7 - i);
    check("wrap_full", 32'(full), 1);
    code_in = 3'd5; code_vld = 1'b1; out_ready = 1'b1;
    #1;
    check("wrap_head_pre", 32'(out_code), 7);
    step();
    code_vld = 1'b0; out_ready = 1'b0;
    check("wrap_count", 32'(count), 8);
    check("wrap_ovf", 32'(overflow), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("wrap_drain_%0d", i), 32'(out_code), (i < 7) ? 32'(6 - i) : 32'd5);
      step();
    end
    out_ready = 1'b0;
    check("wrap_empty", 32'(count), 0);

`ifdef CODE_PARITY_EN
    check("par_empty", 32'(out_par), 0);
    push(3);
    check("par_011", 32'(out_par), 0);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    push(7);
    check("par_111", 32'(out_par), 1);
    out_ready = 1'b1; step(); out_ready = 1'b0;
`endif

    // asynchronous reset mid-stream
    push(1); push(2); push(3);
    check("pre_rst_count", 32'(count), 3);
    #2;
    rst = 1'b1;
    #1;
    check("arst_count", 32'(count), 0);
    check("arst_empty", 32'(empty), 1);
    check("arst_valid", 32'(out_valid), 0);
    check("arst_ovf", 32'(overflow), 0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_count", 32'(count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
